msft_rst_seq: RTL and testbench
===============================

// Module: msft_rst_seq
// PURPOSE
//  Reset-release sequencer on the consuming end of the global clock buffer.
//  Asynchronously asserts all downstream resets and releases them synchronously, in staged order, once the
//  clock source reports stable lock. Provides a software-triggered full-reset handshake.
//  Sits between board reset/MMCM-lock and the core, bus fabric and peripheral reset nets on the Arty A7 top.
// PARAMETERS
//  NUM_STAGES    3   number of staged reset outputs; stage 0 is released first.
//  SYNC_DEPTH    2   flops in the reset-deassert synchronizer (min 2).
//  LOCK_CYCLES   16  consecutive cycles of synced lock required before stage 0 is released (min 1).
//  STAGE_GAP     8   cycles between successive stage releases (min 1).
//  SWRST_CYCLES  32  cycles all stages are held low for a software reset (min 1).
// PORTS
//  clk_i         in   1           buffered system clock; single clock domain.
//  rstn_i        in   1           asynchronous, active-low reset.
//  pll_locked_i  in   1           MMCM lock; asynchronous to clk_i, synchronized internally.
//  swrst_req_i   in   1           software reset request (level); acted on at its rising edge in RUN.
//  swrst_ack_o   out  1           one-cycle pulse when the software reset completes.
//  rstn_o        out  NUM_STAGES  active-low staged resets; asserted asynchronously, released synchronously.
//  seq_done_o    out  1           high while in RUN, when all stages are released.
// BEHAVIOUR
//  Reset: rstn_i low clears every flop asynchronously.
//   Output values: rstn_o='0, seq_done_o=0, swrst_ack_o=0, state=WAIT_LOCK, counters 0.
//  Internal reset: rstn_i passes through a SYNC_DEPTH chain (async clear, D=1).
//   All other flops use the chain output as their async-low reset.
//  Lock synchronizer: pll_locked_i passes through a 2-flop synchronizer, held clear by the internal reset.
//  States: WAIT_LOCK, STAGING, RUN, SWRST.
//  WAIT_LOCK: all rstn_o low.
//   - cnt increments while synced lock=1 and clears when it is 0.
//   - When cnt==LOCK_CYCLES-1 and lock=1, go to STAGING: rstn_o[0]=1 and cnt=0 on the same edge.
//  STAGING: cnt counts to STAGE_GAP-1, then releases the next stage and clears cnt.
//   - The edge that releases stage NUM_STAGES-1 also enters RUN and sets seq_done_o=1.
//  RUN: on a swrst_req_i rising edge (req=1 while req_q=0), the next edge sets rstn_o='0 and seq_done_o=0,
//   and the state goes to SWRST.
//  SWRST: hold for SWRST_CYCLES cycles, then go to STAGING (stage 0 released on that edge).
//   - swrst_ack_o pulses for one cycle on the edge that re-enters RUN.
//  Lock loss: synced lock=0 in STAGING, RUN or SWRST means that on the next edge rstn_o='0, seq_done_o=0,
//   cnt=0 and state=WAIT_LOCK.
//   - A pending software reset is dropped and no ack is given.
//   - Lock loss has priority over every other transition in the same cycle.
//  Request edges seen outside RUN are ignored, and no ack is given for them.
//  A request held high across the ack needs a fresh low-to-high edge to trigger again.
//  Latency (defaults, lock steady high): counted from the first clk_i edge with rstn_i high,
//   stage 0 releases on edge SYNC_DEPTH+2+LOCK_CYCLES = 20. Stage 1 releases at 28, stage 2 at 36.
//  Counter width CNT_W = $clog2(max(LOCK_CYCLES, STAGE_GAP, SWRST_CYCLES)+1). The counter never wraps.
// CONFIGURATION
//  MSFT_RST_SEQ_STATS_EN defined: adds port rst_events_o [7:0].
//   - It counts entries into WAIT_LOCK from lock loss plus entries into SWRST.
//   - It saturates at 8'hFF and is cleared only by rstn_i.
//  MSFT_RST_SEQ_STATS_EN undefined: the port and counter are absent; all other behaviour is identical.
// STRUCTURE
//  Package msft_rst_seq_pkg:
//   - rst_seq_state_e enum {WAIT_LOCK, STAGING, RUN, SWRST}, 2 bits.
//   - Function cnt_w(a, b, c) returning the CNT_W value.
//  Sub-module msft_sync_ff #(DEPTH): a reset-cleared flop chain.
//   - Instanced once for the rstn_i deassert chain (DEPTH=SYNC_DEPTH) and once for pll_locked_i (DEPTH=2).
//  Stage index counter, FSM and output registers stay in msft_rst_seq.
// TESTING
//  1. Defaults, lock high, release rstn_i -> rstn_o[0]/[1]/[2] rise at edges 20/28/36;
//     seq_done_o rises at edge 36.
//  2. Lock toggles low for 1 cycle at edge 15 of WAIT_LOCK count -> count restarts;
//     stage 0 is delayed by the full LOCK_CYCLES.
//  3. In RUN, swrst_req_i 0->1 held high -> rstn_o=3'b000 for 32 cycles, restaged 0/8/16 cycles later;
//     one swrst_ack_o pulse; no retrigger while req stays high.
//  4. Drop pll_locked_i in SWRST and in STAGING -> all outputs low 3 edges later (2 sync + 1);
//     WAIT_LOCK; no ack.
//  5. Assert rstn_i mid-STAGING -> rstn_o='0 and seq_done_o=0 immediately (asynchronous), before the next edge.
//  6. MSFT_RST_SEQ_STATS_EN: 300 software resets -> rst_events_o saturates at 8'hFF;
//     macro off -> build has no rst_events_o.

Source files
------------

// File: rtl/msft_rst_seq_pkg.sv
// msft_rst_seq_pkg -- shared state encoding and counter sizing for the reset sequencer.
// Rev 1.0
`default_nettype none

package msft_rst_seq_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STAGING   = 2'd1,
    RUN       = 2'd2,
    SWRST     = 2'd3
  } rst_seq_state_e;

  // Width that holds the largest of the three cycle counts without wrapping.
  function automatic int cnt_w(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/msft_sync_ff.sv
// msft_sync_ff -- reset-cleared flop chain used as a synchronizer.
// Rev 1.0
`default_nettype none

module msft_sync_ff #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain <= '0;
    else        chain <= {chain[DEPTH-2:0], d};
  end

  assign q = chain[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/msft_rst_seq.sv
// msft_rst_seq -- staged reset-release sequencer with software reset handshake.
// Optional MSFT_RST_SEQ_STATS_EN adds rst_events_o (saturating reset-event counter). Rev 1.0
`default_nettype none

module msft_rst_seq
  import msft_rst_seq_pkg::*;
#(
  parameter int NUM_STAGES   = 3,
  parameter int SYNC_DEPTH   = 2,
  parameter int LOCK_CYCLES  = 16,
  parameter int STAGE_GAP    = 8,
  parameter int SWRST_CYCLES = 32
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  pll_locked_i,
  input  logic                  swrst_req_i,
  output logic                  swrst_ack_o,
  output logic [NUM_STAGES-1:0] rstn_o,
  output logic                  seq_done_o
`ifdef MSFT_RST_SEQ_STATS_EN
  ,
  output logic [7:0]            rst_events_o
`endif
);

  localparam int CNT_W  = cnt_w(LOCK_CYCLES, STAGE_GAP, SWRST_CYCLES);
  localparam int SIDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0] SW_LAST   = CNT_W'(SWRST_CYCLES - 1);
  localparam logic [SIDX_W-1:0] PEN_IDX  = SIDX_W'(NUM_STAGES - 2);

  logic int_rstn;
  logic lock;

  msft_sync_ff #(.DEPTH(SYNC_DEPTH)) u_rst_sync (
    .clk   (clk_i),
    .rst_n (rstn_i),
    .d     (1'b1),
    .q     (int_rstn)
  );

  msft_sync_ff #(.DEPTH(2)) u_lock_sync (
    .clk   (clk_i),
    .rst_n (int_rstn),
    .d     (pll_locked_i),
    .q     (lock)
  );

  rst_seq_state_e        state, state_d;
  logic [CNT_W-1:0]      cnt, cnt_d;
  logic [SIDX_W-1:0]     sidx, sidx_d;
  logic [NUM_STAGES-1:0] rstn_q, rstn_d;
  logic                  done_q, done_d;
  logic                  ack_q, ack_d;
  logic                  pend_q, pend_d;
  logic                  req_q;
  logic                  req_rise;
  logic                  first;

  assign req_rise = swrst_req_i & ~req_q;

  always_ff @(posedge clk_i or negedge int_rstn) begin
    if (!int_rstn) begin
      state  <= WAIT_LOCK;
      cnt    <= '0;
      sidx   <= '0;
      rstn_q <= '0;
      done_q <= 1'b0;
      ack_q  <= 1'b0;
      pend_q <= 1'b0;
      req_q  <= 1'b0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      sidx   <= sidx_d;
      rstn_q <= rstn_d;
      done_q <= done_d;
      ack_q  <= ack_d;
      pend_q <= pend_d;
      req_q  <= swrst_req_i;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    sidx_d  = sidx;
    rstn_d  = rstn_q;
    done_d  = done_q;
    ack_d   = 1'b0;
    pend_d  = pend_q;
    first   = 1'b0;

    unique case (state)
      WAIT_LOCK: begin
        if (!lock)                 cnt_d = '0;
        else if (cnt == LOCK_LAST) first = 1'b1;
        else                       cnt_d = cnt + CNT_W'(1);
      end
      STAGING: begin
        if (cnt == GAP_LAST) begin
          cnt_d  = '0;
          sidx_d = sidx + SIDX_W'(1);
          rstn_d = (rstn_q << 1) | NUM_STAGES'(1);
          if (sidx == PEN_IDX) begin
            state_d = RUN;
            done_d  = 1'b1;
            ack_d   = pend_q;
            pend_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      RUN: begin
        if (req_rise) begin
          state_d = SWRST;
          rstn_d  = '0;
          done_d  = 1'b0;
          cnt_d   = '0;
          pend_d  = 1'b1;
        end
      end
      SWRST: begin
        if (cnt == SW_LAST) first = 1'b1;
        else                cnt_d = cnt + CNT_W'(1);
      end
      default: state_d = WAIT_LOCK;
    endcase

    // Stage 0 release is shared by lock acquisition and software-reset exit.
    if (first) begin
      cnt_d  = '0;
      sidx_d = '0;
      rstn_d = NUM_STAGES'(1);
      if (NUM_STAGES == 1) begin
        state_d = RUN;
        done_d  = 1'b1;
        ack_d   = pend_q;
        pend_d  = 1'b0;
      end else begin
        state_d = STAGING;
      end
    end

    // Lock loss overrides everything decided above.
    if (state != WAIT_LOCK && !lock) begin
      state_d = WAIT_LOCK;
      cnt_d   = '0;
      sidx_d  = '0;
      rstn_d  = '0;
      done_d  = 1'b0;
      ack_d   = 1'b0;
      pend_d  = 1'b0;
    end
  end

  assign rstn_o      = rstn_q;
  assign seq_done_o  = done_q;
  assign swrst_ack_o = ack_q;

`ifdef MSFT_RST_SEQ_STATS_EN
  logic [7:0] evt_q;
  logic       evt_inc;

  assign evt_inc = (state != WAIT_LOCK) && (!lock || (state == RUN && req_rise));

  always_ff @(posedge clk_i or negedge int_rstn) begin
    if (!int_rstn)                    evt_q <= '0;
    else if (evt_inc && evt_q != 8'hFF) evt_q <= evt_q + 8'd1;
  end

  assign rst_events_o = evt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_msft_rst_seq.sv
// tb_msft_rst_seq -- directed stimulus with a cycle-level behavioural model of the reset sequencer.
`default_nettype none

module tb_msft_rst_seq;

  localparam int N   = 3;
  localparam int SD  = 2;
  localparam int LC  = 16;
  localparam int GAP = 8;
  localparam int SW  = 32;

  localparam int P_WAIT  = 0;
  localparam int P_STAGE = 1;
  localparam int P_RUN   = 2;
  localparam int P_SW    = 3;

  logic         clk;
  logic         rstn_i;
  logic         pll_locked_i;
  logic         swrst_req_i;
  logic         swrst_ack_o;
  logic [N-1:0] rstn_o;
  logic         seq_done_o;
`ifdef MSFT_RST_SEQ_STATS_EN
  logic [7:0]   rst_events;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 0;

  msft_rst_seq #(
    .NUM_STAGES   (N),
    .SYNC_DEPTH   (SD),
    .LOCK_CYCLES  (LC),
    .STAGE_GAP    (GAP),
    .SWRST_CYCLES (SW)
  ) dut (
    .clk_i        (clk),
    .rstn_i       (rstn_i),
    .pll_locked_i (pll_locked_i),
    .swrst_req_i  (swrst_req_i),
    .swrst_ack_o  (swrst_ack_o),
    .rstn_o       (rstn_o),
    .seq_done_o   (seq_done_o)
`ifdef MSFT_RST_SEQ_STATS_EN
    ,
    .rst_events_o (rst_events)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: phases with elapsed-cycle counts; stage releases derived arithmetically.
  int m_chain, m_phase, m_run, m_t, m_evt;
  bit m_p0, m_p1, m_pend, m_reqp, m_ack;

  task automatic model_reset();
    m_chain = 0; m_phase = P_WAIT; m_run = 0; m_t = 0; m_evt = 0;
    m_p0 = 0; m_p1 = 0; m_pend = 0; m_reqp = 0; m_ack = 0;
  endtask

  task automatic model_edge();
    bit lk;
    m_ack = 0;
    if (m_chain >= SD) begin
      lk = m_p1;
      if (m_phase != P_WAIT && !lk) begin
        m_phase = P_WAIT; m_run = 0; m_pend = 0;
        if (m_evt < 255) m_evt++;
      end else begin
        case (m_phase)
          P_WAIT: begin
            m_run = lk ? m_run + 1 : 0;
            if (m_run == LC) begin m_phase = P_STAGE; m_t = 0; m_run = 0; end
          end
          P_STAGE: begin
            m_t++;
            if (m_t == (N - 1) * GAP) begin m_phase = P_RUN; m_ack = m_pend; m_pend = 0; end
          end
          P_RUN: begin
            if (swrst_req_i && !m_reqp) begin
              m_phase = P_SW; m_t = 0; m_pend = 1;
              if (m_evt < 255) m_evt++;
            end
          end
          default: begin
            m_t++;
            if (m_t == SW) begin m_phase = P_STAGE; m_t = 0; end
          end
        endcase
      end
      m_reqp = swrst_req_i;
      m_p1 = m_p0;
      m_p0 = pll_locked_i;
    end
    if (m_chain < SD) m_chain++;
  endtask

  function automatic logic [N-1:0] exp_rstn();
    int rel;
    case (m_phase)
      P_STAGE: rel = 1 + m_t / GAP;
      P_RUN:   rel = N;
      default: rel = 0;
    endcase
    if (rel > N) rel = N;
    return N'((1 << rel) - 1);
  endfunction

  always @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) model_reset();
    else         model_edge();
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_rstn", 32'(rstn_o), 32'(exp_rstn()));
      check("cyc_flags", 32'({seq_done_o, swrst_ack_o}), 32'({m_phase == P_RUN, m_ack}));
`ifdef MSFT_RST_SEQ_STATS_EN
      check("cyc_events", 32'(rst_events), 32'(m_evt));
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks;
    int d;
    rstn_i = 1'b0; pll_locked_i = 1'b1; swrst_req_i = 1'b0;
    repeat (3) step();
    check("reset_rstn", 32'(rstn_o), 32'd0);
    check("reset_done", 32'(seq_done_o), 32'd0);
    check("reset_ack", 32'(swrst_ack_o), 32'd0);
    cmp_en = 1;

    // Power-up release timing with lock steady high.
    rstn_i = 1'b1;
    for (int e = 1; e <= 36; e++) begin
      step();
      if (e == 19) check("pu_e19", 32'(rstn_o), 32'b000);
      if (e == 20) check("pu_e20", 32'(rstn_o), 32'b001);
      if (e == 27) check("pu_e27", 32'(rstn_o), 32'b001);
      if (e == 28) check("pu_e28", 32'(rstn_o), 32'b011);
      if (e == 35) check("pu_done35", 32'(seq_done_o), 32'd0);
      if (e == 36) check("pu_e36", 32'({rstn_o, seq_done_o}), 32'b1111);
    end

    // Software reset with request held high.
    repeat (5) step();
    swrst_req_i = 1'b1;
    acks = 0;
    for (int k = 1; k <= 60; k++) begin
      step();
      acks += int'(swrst_ack_o);
      if (k == 1)  check("sw_entry", 32'({rstn_o, seq_done_o}), 32'b0000);
      if (k == 32) check("sw_hold31", 32'(rstn_o), 32'b000);
      if (k == 33) check("sw_st0", 32'(rstn_o), 32'b001);
      if (k == 41) check("sw_st1", 32'(rstn_o), 32'b011);
      if (k == 49) check("sw_ack", 32'({rstn_o, swrst_ack_o}), 32'b1111);
      if (k == 50) check("sw_ack_end", 32'(swrst_ack_o), 32'd0);
    end
    check("sw_ack_count", 32'(acks), 32'd1);
    acks = 0;
    repeat (30) begin step(); acks += int'(swrst_ack_o); end
    check("sw_no_retrig", 32'({acks[3:0], seq_done_o}), 32'b00001);
    swrst_req_i = 1'b0;
    repeat (3) step();

    // Asynchronous reset while staging.
    swrst_req_i = 1'b1; step(); swrst_req_i = 1'b0;
    repeat (35) step();
    check("as_pre", 32'(rstn_o), 32'b001);
    #3 rstn_i = 1'b0;
    #1;
    check("as_async", 32'({rstn_o, seq_done_o}), 32'b0000);

    // Lock glitch during the lock count; request raised outside RUN.
    step();
    rstn_i = 1'b1;
    for (int e = 1; e <= 60; e++) begin
      step();
      if (e == 14) pll_locked_i = 1'b0;
      if (e == 15) pll_locked_i = 1'b1;
      if (e == 20) check("gl_e20", 32'(rstn_o), 32'b000);
      if (e == 32) check("gl_e32", 32'(rstn_o), 32'b000);
      if (e == 33) check("gl_e33", 32'(rstn_o), 32'b001);
      if (e == 34) swrst_req_i = 1'b1;
      if (e == 49) check("gl_run", 32'(seq_done_o), 32'd1);
      if (e == 60) check("ign_req", 32'({rstn_o, seq_done_o}), 32'b1111);
    end
    swrst_req_i = 1'b0;

    // Lock loss during software reset: pending ack dropped.
    swrst_req_i = 1'b1; step(); swrst_req_i = 1'b0;
    repeat (10) step();
    pll_locked_i = 1'b0;
    repeat (3) step();
    check("ll_sw_done", 32'(seq_done_o), 32'd0);
    pll_locked_i = 1'b1;
    acks = 0;
    for (int j = 4; j <= 40; j++) begin
      step();
      acks += int'(swrst_ack_o);
      if (j == 20) check("ll_sw_e20", 32'(rstn_o), 32'b000);
      if (j == 21) check("ll_sw_e21", 32'(rstn_o), 32'b001);
    end
    check("ll_sw_noack", 32'({acks[3:0], seq_done_o}), 32'b00001);

    // Lock loss during staging.
    swrst_req_i = 1'b1; step(); swrst_req_i = 1'b0;
    repeat (34) step();
    pll_locked_i = 1'b0;
    step(); step();
    check("ll_st_d2", 32'(rstn_o), 32'b001);
    step();
    check("ll_st_d3", 32'({rstn_o, seq_done_o}), 32'b0000);
    pll_locked_i = 1'b1;
    acks = 0;
    repeat (40) begin step(); acks += int'(swrst_ack_o); end
    check("ll_st_noack", 32'({acks[3:0], seq_done_o}), 32'b00001);

`ifdef MSFT_RST_SEQ_STATS_EN
    for (int r = 0; r < 300; r++) begin
      swrst_req_i = 1'b1; step(); swrst_req_i = 1'b0;
      repeat (50) step();
    end
    check("ev_sat", 32'(rst_events), 32'hFF);
`endif

    d = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + d);
    $finish;
  end

endmodule

`default_nettype wire
